// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and owner codes.
package mem_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data access (D).
// Data wins over fetch, except that a fetch kept waiting through STARVE_MAX
// consecutive data grants is forced through. One transaction outstanding at a
// time; a watchdog aborts a transaction the memory never acknowledges.
//
//  state | meaning
//  IDLE  | no transaction; arbitrate when no completion pulse is out
//  BUSY  | o_mem_* driven and held, waiting for i_mem_ack or the watchdog
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 16,
   parameter int DW         = 16,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_if_req,
   input  logic [AW-1:0] i_if_addr,
   output logic          o_if_ack,
   output logic [DW-1:0] o_if_rdata,
   input  logic          i_d_req,
   input  logic          i_d_we,
   input  logic [AW-1:0] i_d_addr,
   input  logic [DW-1:0] i_d_wdata,
   output logic          o_d_ack,
   output logic [DW-1:0] o_d_rdata,
   output logic          o_mem_req,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic          i_mem_ack,
   input  logic [DW-1:0] i_mem_rdata,
   output logic          o_busy,
   output logic          o_owner,
   output logic          o_err
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   arb_state_e    state_q;
   logic [SW-1:0] starve_q, starve_d;
   logic [TW-1:0] timer_q;
   logic          mem_req_q, mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic          if_ack_q, d_ack_q;
   logic [DW-1:0] if_rdata_q, d_rdata_q;
   logic          owner_q;
   logic          err_q;

   logic          if_pend, d_pend, arb_en;
   logic          grant_if, grant_d;
   logic          done, done_err;
   logic [DW-1:0] done_rdata;

   // Arbitration and starvation-counter next value. While a completion pulse
   // is out the requesters are updating their req lines, so no grant is made
   // in that cycle; a requester that re-raises right after its ack therefore
   // competes on equal terms in the following IDLE cycle.
   always_comb begin
      if_pend  = i_if_req & ~if_ack_q;
      d_pend   = i_d_req & ~d_ack_q;
      arb_en   = (state_q == IDLE) & ~if_ack_q & ~d_ack_q;
      grant_d  = arb_en & d_pend & ~(if_pend & (starve_q == STARVE_TOP));
      grant_if = arb_en & if_pend & ~grant_d;
      starve_d = starve_q;
      if (grant_d && if_pend) begin
         if (starve_q != STARVE_TOP) begin
            starve_d = starve_q + 1'b1;
         end
      end else if (grant_d || grant_if) begin
         starve_d = '0;
      end
   end

   // Completion of the BUSY transaction: memory ack, or watchdog expiry.
   // Writes and aborts return zero data.
   always_comb begin
      done       = (state_q == BUSY) & (i_mem_ack | (timer_q == TIMER_LAST));
      done_err   = (state_q == BUSY) & ~i_mem_ack & (timer_q == TIMER_LAST);
      done_rdata = (i_mem_ack && !mem_we_q) ? i_mem_rdata : '0;
   end

   // Arbiter FSM with all outputs registered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         timer_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         owner_q     <= OWN_IF;
         err_q       <= 1'b0;
      end else begin
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         starve_q <= starve_d;
         case (state_q)
            IDLE: begin
               if (grant_if || grant_d) begin
                  state_q     <= BUSY;
                  timer_q     <= '0;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= grant_d & i_d_we;
                  mem_addr_q  <= grant_d ? i_d_addr : i_if_addr;
                  mem_wdata_q <= grant_d ? i_d_wdata : '0;
                  owner_q     <= grant_d ? OWN_D : OWN_IF;
               end
            end
            BUSY: begin
               if (done) begin
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
                  if (owner_q == OWN_D) begin
                     d_ack_q   <= 1'b1;
                     d_rdata_q <= done_rdata;
                  end else begin
                     if_ack_q   <= 1'b1;
                     if_rdata_q <= done_rdata;
                  end
                  if (done_err) begin
                     err_q <= 1'b1;
                  end
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_if_ack    = if_ack_q;
   assign o_if_rdata  = if_rdata_q;
   assign o_d_ack     = d_ack_q;
   assign o_d_rdata   = d_rdata_q;
   assign o_mem_req   = mem_req_q;
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_busy      = (state_q == BUSY);
   assign o_owner     = owner_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a memory responder, scoreboard queues of
// expected memory transactions and expected requester completions, a table
// of single transactions, and hand-written multi-cycle sequences.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic        i_if_req, i_d_req, i_d_we, i_mem_ack;
   logic [15:0] i_if_addr, i_d_addr, i_d_wdata, i_mem_rdata;
   logic        o_if_ack, o_d_ack, o_mem_req, o_mem_we, o_busy, o_owner, o_err;
   logic [15:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .i_clk(clk), .i_rst_n(i_rst_n),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_ack(o_if_ack), .o_if_rdata(o_if_rdata),
      .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
      .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
      .o_busy(o_busy), .o_owner(o_owner), .o_err(o_err)
   );

   // lat: BUSY cycles before the responder acks (0 = same cycle as o_mem_req), -1 = never
   typedef struct {
      logic        own;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          lat;
   } mem_t;

   typedef struct {
      logic        is_d;
      logic [15:0] rdata;
   } ack_t;

   typedef struct {
      logic        if_req;
      logic [15:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [15:0] d_addr;
      logic [15:0] d_wdata;
      logic [15:0] mem_rdata;
      int          lat;
      logic        exp_own;
      logic        exp_we;
      logic [15:0] exp_addr;
      logic [15:0] exp_wdata;
      logic [15:0] exp_rdata;
   } vec_t;

   mem_t mem_q[$];
   ack_t ack_q[$];

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   acks_seen = 0;
   int   last_ack_cyc = 0;
   int   mem_start_cyc = 0;
   int   busy_cyc = 0;
   int   last_busy_len = 0;
   logic in_txn = 1'b0;
   logic stable_ok = 1'b1;
   mem_t cur;
   logic d_repeat = 1'b0;
   logic d_rearm = 1'b0;
   logic stray = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: sample outputs 1ns after the edge, score completions, run the
   // requesters' drop/re-raise and the memory responder.
   task automatic tick();
      ack_t a;
      @(posedge clk);
      #1;
      cyc++;
      if (d_rearm) begin
         i_d_req = 1'b1;
         d_rearm = 1'b0;
      end
      if (o_if_ack || o_d_ack) begin
         acks_seen++;
         last_ack_cyc = cyc;
         if (ack_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ack: if_ack=%0b d_ack=%0b, required none (cycle %0d)",
                     o_if_ack, o_d_ack, cyc);
         end else begin
            a = ack_q.pop_front();
            check("ack_onehot", o_if_ack ^ o_d_ack, 1);
            check("ack_owner", o_d_ack, a.is_d);
            check("ack_rdata", a.is_d ? o_d_rdata : o_if_rdata, a.rdata);
         end
         if (o_if_ack) i_if_req = 1'b0;
         if (o_d_ack) begin
            i_d_req = 1'b0;
            if (d_repeat) d_rearm = 1'b1;
         end
      end
      check("busy_vs_req", o_busy, o_mem_req);
      if (o_mem_req) begin
         if (!in_txn) begin
            in_txn        = 1'b1;
            busy_cyc      = 0;
            stable_ok     = 1'b1;
            mem_start_cyc = cyc;
            if (mem_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_grant: owner=%0b addr=%0h, required none (cycle %0d)",
                        o_owner, o_mem_addr, cyc);
               cur = '{own: o_owner, we: o_mem_we, addr: o_mem_addr, wdata: o_mem_wdata,
                       rdata: 16'h0, lat: 0};
            end else begin
               cur = mem_q.pop_front();
               check("grant_owner", o_owner, cur.own);
               check("mem_we", o_mem_we, cur.we);
               check("mem_addr", o_mem_addr, cur.addr);
               check("mem_wdata", o_mem_wdata, cur.wdata);
            end
         end else if ({o_mem_we, o_mem_addr, o_mem_wdata} !== {cur.we, cur.addr, cur.wdata}) begin
            stable_ok = 1'b0;
         end
         if (cur.lat >= 0 && busy_cyc == cur.lat) begin
            i_mem_ack   = 1'b1;
            i_mem_rdata = cur.rdata;
         end else begin
            i_mem_ack   = 1'b0;
            i_mem_rdata = 16'hDEAD;
         end
         busy_cyc++;
      end else begin
         if (in_txn) begin
            in_txn        = 1'b0;
            last_busy_len = busy_cyc;
            check("mem_stable", stable_ok, 1);
         end
         i_mem_ack   = stray;
         i_mem_rdata = 16'hBAD0;
         stray       = 1'b0;
      end
   endtask

   task automatic wait_acks(input int n, input int budget, input string name);
      int target;
      int k;
      target = acks_seen + n;
      k = 0;
      while (acks_seen < target && k < budget) begin
         tick();
         k++;
      end
      if (acks_seen < target) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: acks seen %0d, required %0d", name, acks_seen, target);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      vec_t vecs[5];
      int   t0;
      int   td;
      int   k;

      vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h2005, 0,
                  OWN_IF, 1'b0, 16'h0010, 16'h0000, 16'h2005};
      vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h5555, 16'hBEEF, 2,
                  OWN_D, 1'b0, 16'h1234, 16'h5555, 16'hBEEF};
      vecs[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000, 16'h6700, 16'h1111, 1,
                  OWN_D, 1'b1, 16'h8000, 16'h6700, 16'h0000};
      vecs[3] = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 16'h9999, 16'h9999, 16'hA5A5, 3,
                  OWN_IF, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5};
      vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0C0C, 16'hC0DE, 16'h7777, 5,
                  OWN_D, 1'b1, 16'h0C0C, 16'hC0DE, 16'h0000};

      i_rst_n     = 1'b0;
      i_if_req    = 1'b0;
      i_d_req     = 1'b0;
      i_d_we      = 1'b0;
      i_if_addr   = 16'h0;
      i_d_addr    = 16'h0;
      i_d_wdata   = 16'h0;
      i_mem_ack   = 1'b0;
      i_mem_rdata = 16'h0;

      // reset state
      tick();
      tick();
      check("reset_outputs",
            {o_if_ack, o_d_ack, o_mem_req, o_mem_we, o_busy, o_owner, o_err,
             o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata}, 64'h0);
      i_rst_n = 1'b1;
      tick();

      // single transactions: grant, latched fields, completion data, latency
      for (int i = 0; i < 5; i++) begin
         i_if_addr = vecs[i].if_addr;
         i_d_we    = vecs[i].d_we;
         i_d_addr  = vecs[i].d_addr;
         i_d_wdata = vecs[i].d_wdata;
         mem_q.push_back('{own: vecs[i].exp_own, we: vecs[i].exp_we, addr: vecs[i].exp_addr,
                           wdata: vecs[i].exp_wdata, rdata: vecs[i].mem_rdata, lat: vecs[i].lat});
         ack_q.push_back('{is_d: vecs[i].exp_own, rdata: vecs[i].exp_rdata});
         i_if_req = vecs[i].if_req;
         i_d_req  = vecs[i].d_req;
         t0 = cyc;
         wait_acks(1, 40, "vec");
         check("vec_latency", last_ack_cyc - t0, vecs[i].lat + 2);
         check("vec_busy_len", last_busy_len, vecs[i].lat + 1);
         tick();
      end

      // both request together: data first, fetch after the arbitration cycle
      i_d_we    = 1'b1;
      i_d_addr  = 16'h8000;
      i_d_wdata = 16'h6700;
      i_if_addr = 16'h0020;
      mem_q.push_back('{own: OWN_D, we: 1'b1, addr: 16'h8000, wdata: 16'h6700, rdata: 16'h3333, lat: 0});
      mem_q.push_back('{own: OWN_IF, we: 1'b0, addr: 16'h0020, wdata: 16'h0000, rdata: 16'h0202, lat: 0});
      ack_q.push_back('{is_d: 1'b1, rdata: 16'h0000});
      ack_q.push_back('{is_d: 1'b0, rdata: 16'h0202});
      i_if_req = 1'b1;
      i_d_req  = 1'b1;
      t0 = cyc;
      wait_acks(1, 20, "both_d");
      td = last_ack_cyc;
      check("both_d_latency", td - t0, 2);
      wait_acks(1, 20, "both_if");
      check("both_if_gap", mem_start_cyc - td, 2);
      tick();

      // starvation guard: four data grants, then the waiting fetch, then data again
      i_d_we    = 1'b0;
      i_d_addr  = 16'h4000;
      i_d_wdata = 16'h0000;
      i_if_addr = 16'h0030;
      for (int j = 0; j < 4; j++) begin
         mem_q.push_back('{own: OWN_D, we: 1'b0, addr: 16'h4000, wdata: 16'h0000,
                           rdata: 16'h4000 + 16'(j), lat: 0});
         ack_q.push_back('{is_d: 1'b1, rdata: 16'h4000 + 16'(j)});
      end
      mem_q.push_back('{own: OWN_IF, we: 1'b0, addr: 16'h0030, wdata: 16'h0000, rdata: 16'h3030, lat: 0});
      ack_q.push_back('{is_d: 1'b0, rdata: 16'h3030});
      mem_q.push_back('{own: OWN_D, we: 1'b0, addr: 16'h4000, wdata: 16'h0000, rdata: 16'h4005, lat: 0});
      ack_q.push_back('{is_d: 1'b1, rdata: 16'h4005});
      d_repeat = 1'b1;
      i_if_req = 1'b1;
      i_d_req  = 1'b1;
      wait_acks(4, 60, "starve_d");
      check("starve_at_max", dut.starve_q, 4);
      tick();
      tick();
      check("starve_if_granted", {o_mem_req, o_owner}, {1'b1, OWN_IF});
      check("starve_cleared", dut.starve_q, 0);
      wait_acks(2, 30, "starve_tail");
      d_repeat = 1'b0;
      d_rearm  = 1'b0;
      i_d_req  = 1'b0;
      check("starve_queue_drained", mem_q.size(), 0);
      tick();

      // memory never acks: watchdog abort, sticky error, late ack ignored
      i_d_we   = 1'b0;
      i_d_addr = 16'h00AA;
      mem_q.push_back('{own: OWN_D, we: 1'b0, addr: 16'h00AA, wdata: 16'h0000, rdata: 16'h1234, lat: -1});
      ack_q.push_back('{is_d: 1'b1, rdata: 16'h0000});
      check("err_before_abort", o_err, 0);
      i_d_req = 1'b1;
      wait_acks(1, 40, "abort");
      check("abort_busy_len", last_busy_len, 15);
      check("abort_err", o_err, 1);
      stray = 1'b1;
      for (int j = 0; j < 4; j++) tick();
      check("stray_err_sticky", o_err, 1);
      check("stray_idle", {o_busy, o_mem_req}, 2'b00);
      check("if_rdata_hold", o_if_rdata, 16'h3030);

      // reset while BUSY drops everything at once; pending fetch re-granted afterwards
      i_if_addr = 16'h0050;
      mem_q.push_back('{own: OWN_IF, we: 1'b0, addr: 16'h0050, wdata: 16'h0000, rdata: 16'h0000, lat: -1});
      i_if_req = 1'b1;
      k = 0;
      while (!o_mem_req && k < 10) begin
         tick();
         k++;
      end
      check("rst_busy_reached", o_mem_req, 1);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("rst_async_clear", {o_mem_req, o_busy, o_err, o_if_ack, o_d_ack}, 5'b0);
      in_txn    = 1'b0;
      i_mem_ack = 1'b0;
      mem_q.delete();
      for (int j = 0; j < 3; j++) tick();
      check("rst_hold_idle", {o_mem_req, o_busy}, 2'b00);
      i_rst_n = 1'b1;
      mem_q.push_back('{own: OWN_IF, we: 1'b0, addr: 16'h0050, wdata: 16'h0000, rdata: 16'h5050, lat: 1});
      ack_q.push_back('{is_d: 1'b0, rdata: 16'h5050});
      t0 = cyc;
      wait_acks(1, 20, "after_rst");
      check("after_rst_latency", last_ack_cyc - t0, 3);
      tick();
      check("queues_empty", {32'(mem_q.size()), 32'(ack_q.size())}, 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
